// File: rtl/frame_capture_ctrl.sv
// Pixel-clock frame capture sequencer: gates camera pixel writes into the frame buffer BRAM
// on whole VSYNC-aligned frames, with continuous / snapshot / freeze modes and frame status.
module frame_capture_ctrl #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 307200,
  parameter int unsigned AW    = 19
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_vsync,
  input  logic             i_pix_wr,
  input  logic [WIDTH-1:0] i_pix_data,
  input  logic             i_cont,
  input  logic             i_snap,
  input  logic             i_freeze,
  output logic             o_bram_wr,
  output logic [AW-1:0]    o_bram_addr,
  output logic [WIDTH-1:0] o_bram_data,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [15:0]      o_frame_cnt,
  output logic             o_overflow,
  output logic             o_short
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic             vsync_q;
  logic             snap_pend_q, snap_pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic             short_q, short_d;
  logic             vs_fall, vs_rise;

  assign vs_fall = vsync_q & ~i_vsync;
  assign vs_rise = ~vsync_q & i_vsync;

  always_comb begin
    state_d     = state_q;
    snap_pend_d = snap_pend_q | i_snap;
    cnt_d       = cnt_q;
    ovf_flag_d  = ovf_flag_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    short_d     = short_q;

    case (state_q)
      S_IDLE: begin
        if (!i_freeze && (i_cont || snap_pend_q || i_snap)) begin
          state_d     = S_ARM;
          snap_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        if (i_freeze) begin
          state_d = S_IDLE;
        end else if (vs_fall) begin
          state_d    = S_CAPTURE;
          cnt_d      = '0;
          ovf_flag_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        // A fall here means the rise was missed: restart the frame, dropping this cycle's pixel.
        if (vs_fall) begin
          cnt_d      = '0;
          ovf_flag_d = 1'b0;
        end else begin
          if (i_pix_wr) begin
            if (cnt_q < DEPTH_C) begin
              wr_d   = 1'b1;
              addr_d = cnt_q[AW-1:0];
              data_d = i_pix_data;
              cnt_d  = cnt_q + 1'b1;
            end else begin
              ovf_flag_d = 1'b1;
            end
          end
          if (vs_rise) state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        overflow_d  = ovf_flag_q;
        short_d     = (cnt_q < DEPTH_C);
        state_d     = (i_cont && !i_freeze) ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b1;
      snap_pend_q <= 1'b0;
      cnt_q       <= '0;
      ovf_flag_q  <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= i_vsync;
      snap_pend_q <= snap_pend_d;
      cnt_q       <= cnt_d;
      ovf_flag_q  <= ovf_flag_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      short_q     <= short_d;
    end
  end

  assign o_bram_wr    = wr_q;
  assign o_bram_addr  = addr_q;
  assign o_bram_data  = data_q;
  assign o_busy       = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign o_frame_done = (state_q == S_DONE);
  assign o_frame_cnt  = frame_cnt_q;
  assign o_overflow   = overflow_q;
  assign o_short      = short_q;

endmodule
